// File: rtl/n_bit_subtractor_pkg.sv
// Shared constants for the ripple-borrow subtractor: default operand width
// and the value the registered outputs take while reset is asserted.
package n_bit_subtractor_pkg;
    localparam int   DEFAULT_N = 8;
    localparam logic RST_VAL   = 1'b0;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo set when the stage must borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/n_bit_subtractor.sv
// N-bit ripple-borrow subtractor with combinational diff/bout/ovf and a
// one-cycle registered copy of each that clears asynchronously on rst_n.
module n_bit_subtractor
    import n_bit_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic [N-1:0] diff_q,
    output logic         bout_q,
    output logic         ovf_q
);
    // borrow[i] is the borrow into stage i; borrow[N] leaves the MSB stage.
    logic [N:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < N; i++) begin : g_stage
        full_subtractor u_fs (
            .a  (a[i]),
            .b  (b[i]),
            .bi (borrow[i]),
            .d  (diff[i]),
            .bo (borrow[i+1])
        );
    end

    assign bout = borrow[N];

    // Signed overflow: operands of opposite sign and result sign differs from a.
    assign ovf = (a[N-1] ^ b[N-1]) & (diff[N-1] ^ a[N-1]);

    logic [N-1:0] diff_d;
    logic         bout_d;
    logic         ovf_d;

    assign diff_d = diff;
    assign bout_d = bout;
    assign ovf_d  = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= {N{RST_VAL}};
            bout_q <= RST_VAL;
            ovf_q  <= RST_VAL;
        end else begin
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_n_bit_subtractor.sv
// Self-checking bench for n_bit_subtractor (N = 8): directed table, register
// and reset paths, and a random back-to-back sweep against a reference model.
module tb_n_bit_subtractor;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [N-1:0] diff_q;
    logic         bout_q;
    logic         ovf_q;

    int n_cmp;
    int n_err;

    // Packed result {ovf, bout, diff}.
    logic [N+1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    n_bit_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .diff   (diff),
        .bout   (bout),
        .ovf    (ovf),
        .diff_q (diff_q),
        .bout_q (bout_q),
        .ovf_q  (ovf_q)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N+1:0] model(input logic [N-1:0] ma,
                                           input logic [N-1:0] mb,
                                           input logic mbin);
        logic [N:0] r;
        logic       v;
        r = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
        v = (ma[N-1] != mb[N-1]) && (r[N-1] != ma[N-1]);
        return {v, r};
    endfunction

    // Driver: apply inputs and record the value the registers must capture.
    task automatic drive(input logic [N-1:0] da, input logic [N-1:0] db, input logic dbin);
        a   = da;
        b   = db;
        bin = dbin;
        exp_q.push_back(model(da, db, dbin));
    endtask

    task automatic test_reset;
        logic [N+1:0] exp;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #1;
        n_cmp++;
        if ({ovf_q, bout_q, diff_q} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got %0h expected 0", {ovf_q, bout_q, diff_q});
        end
        a = 8'd10;
        b = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ovf_q, bout_q, diff_q} !== '0) begin
            n_err++;
            $display("FAIL reset_held_with_clk: got %0h expected 0", {ovf_q, bout_q, diff_q});
        end
        n_cmp++;
        if (diff !== 8'd5 || bout !== 1'b0) begin
            n_err++;
            $display("FAIL comb_during_reset: got diff=%0d bout=%0d expected diff=5 bout=0", diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd10, 8'd5, 1'b0);
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if ({ovf_q, bout_q, diff_q} !== exp) begin
            n_err++;
            $display("FAIL first_load_after_reset: got %0h expected %0h", {ovf_q, bout_q, diff_q}, exp);
        end
    endtask

    task automatic test_directed;
        vec_t tbl[10];
        logic [N+1:0] exp;
        tbl = '{
            '{8'd10,  8'd5,   1'b0, 8'd5,   1'b0, 1'b0},
            '{8'd10,  8'd10,  1'b0, 8'd0,   1'b0, 1'b0},
            '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1, 1'b0},
            '{8'd0,   8'd1,   1'b1, 8'd254, 1'b1, 1'b0},
            '{8'd255, 8'd1,   1'b0, 8'd254, 1'b0, 1'b0},
            '{8'd128, 8'd127, 1'b0, 8'd1,   1'b0, 1'b1},
            '{8'd85,  8'd170, 1'b1, 8'd170, 1'b1, 1'b1},
            '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0},
            '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0},
            '{8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1}
        };
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].b, tbl[i].bin);
            #1;
            n_cmp++;
            if ({ovf, bout, diff} !== {tbl[i].ov, tbl[i].bo, tbl[i].d}) begin
                n_err++;
                $display("FAIL directed_comb[%0d]: got ovf=%0d bout=%0d diff=%0d expected ovf=%0d bout=%0d diff=%0d",
                         i, ovf, bout, diff, tbl[i].ov, tbl[i].bo, tbl[i].d);
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({ovf_q, bout_q, diff_q} !== exp) begin
                n_err++;
                $display("FAIL directed_reg[%0d]: got %0h expected %0h", i, {ovf_q, bout_q, diff_q}, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [N+1:0] exp;
        @(negedge clk);
        drive(8'd10, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (diff_q !== 8'd5 || {ovf_q, bout_q, diff_q} !== exp) begin
            n_err++;
            $display("FAIL reg_path: got diff_q=%0d expected 5", diff_q);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ovf_q, bout_q, diff_q} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_regs: got %0h expected 0", {ovf_q, bout_q, diff_q});
        end
        n_cmp++;
        if (diff !== 8'd5 || bout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_comb: got diff=%0d bout=%0d expected diff=5 bout=0", diff, bout);
        end
        @(negedge clk);
        a = 8'd0;
        b = 8'd1;
        bin = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (diff_q !== 8'd255 || bout_q !== 1'b1 || ovf_q !== 1'b0) begin
            n_err++;
            $display("FAIL reload_after_reset: got diff_q=%0d bout_q=%0d ovf_q=%0d expected 255 1 0",
                     diff_q, bout_q, ovf_q);
        end
    endtask

    task automatic test_back_to_back;
        logic [N+1:0] exp;
        logic [N+1:0] now;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if ({ovf_q, bout_q, diff_q} !== exp) begin
                    n_err++;
                    $display("FAIL random_reg[%0d]: got %0h expected %0h", i, {ovf_q, bout_q, diff_q}, exp);
                end
            end
            drive(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            now = model(a, b, bin);
            #1;
            n_cmp++;
            if ({ovf, bout, diff} !== now) begin
                n_err++;
                $display("FAIL random_comb[%0d]: a=%0d b=%0d bin=%0d got %0h expected %0h",
                         i, a, b, bin, {ovf, bout, diff}, now);
            end
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if ({ovf_q, bout_q, diff_q} !== exp) begin
            n_err++;
            $display("FAIL random_reg_drain: got %0h expected %0h", {ovf_q, bout_q, diff_q}, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/n_bit_subtractor.md
N_BIT_SUBTRACTOR -- requirements
Module: n_bit_subtractor

Interface
REQ-001 Parameter N, default 8: operand and difference width in bits; SHALL be legal for N >= 1.
REQ-002 clk  input  1  single clock for the registered outputs; rising-edge active.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 a  input  N  minuend, unsigned.
REQ-005 b  input  N  subtrahend, unsigned.
REQ-006 bin  input  1  borrow-in; subtracted as weight 1.
REQ-007 diff  output  N  combinational difference, low N bits of a - b - bin.
REQ-008 bout  output  1  combinational borrow-out, 1 when a < b + bin.
REQ-009 ovf  output  1  combinational two's-complement overflow flag, with a and b treated as signed.
REQ-010 diff_q  output  N  diff registered on clk.
REQ-011 bout_q  output  1  bout registered on clk.
REQ-012 ovf_q  output  1  ovf registered on clk.

Function
REQ-013 {bout, diff} SHALL equal the (N+1)-bit result of {1'b0,a} - {1'b0,b} - bin, evaluated modulo 2^(N+1).
REQ-014 diff, bout and ovf SHALL be purely combinational, with zero latency; they SHALL settle within the same delta/propagation window as input changes, with no dependence on clk or rst_n.
REQ-015 The combinational path SHALL be a ripple-borrow chain:
- stage 0 borrow-in = bin;
- stage i borrow-in = stage i-1 borrow-out;
- bout = stage N-1 borrow-out.
REQ-016 Each stage SHALL compute d = a^b^bi and bo = (~a & b) | (~(a^b) & bi).
REQ-017 ovf SHALL equal a[N-1] != b[N-1] && diff[N-1] != a[N-1].
REQ-018 Boundary: a == b with bin = 0 SHALL give diff = 0 and bout = 0.
REQ-019 Boundary: a = 0, b = 0, bin = 1 SHALL give diff = all-ones and bout = 1, i.e. wrap-around.
REQ-020 Boundary: a = all-ones, b = 0, bin = 0 SHALL give diff = all-ones and bout = 0.
REQ-021 Registered outputs SHALL capture diff, bout and ovf on every rising clk edge, with exactly 1-cycle latency and no enable or handshake.
REQ-022 If an input changes in the same cycle as a clock edge, the registers SHALL take the values settled before that edge (standard setup semantics).

Reset
REQ-023 While rst_n = 0, diff_q, bout_q and ovf_q SHALL be 0 immediately, independent of clk.
REQ-024 On rst_n deassertion, the first rising clk edge SHALL load the current combinational result.
REQ-025 Reset SHALL NOT affect diff, bout or ovf.
REQ-026 Reset asserted mid-operation SHALL discard the registered result with no residual state.

Structure
REQ-027 Shared package n_bit_subtractor_pkg SHALL hold the default-width constant (8) and the reset value constant for the registered outputs.
REQ-028 One sub-module, full_subtractor (ports a, b, bi, d, bo), SHALL be instantiated N times through a generate loop.
REQ-029 There SHALL be no other sub-modules, no latches, and no behavioural "-" operator in the datapath.

Verification
REQ-030 N = 8; a = 10, b = 5, bin = 0 -> diff = 5, bout = 0; a = 10, b = 10, bin = 0 -> diff = 0, bout = 0.
REQ-031 a = 5, b = 10, bin = 0 -> diff = 251, bout = 1; a = 0, b = 1, bin = 1 -> diff = 254, bout = 1.
REQ-032 a = 255, b = 1, bin = 0 -> diff = 254, bout = 0.
REQ-033 a = 128, b = 127, bin = 0 -> diff = 1, bout = 0, ovf = 1.
REQ-034 a = 85, b = 170, bin = 1 -> diff = 170, bout = 1.
REQ-035 Register path: apply a = 10, b = 5 -> diff_q = 5 one edge later.
REQ-036 Reset path: assert rst_n = 0 between edges -> diff_q = 0, bout_q = 0 immediately, while diff stays 5.
REQ-037 Exhaustive/random N = 8 sweep: all outputs SHALL match REQ-013 and REQ-017 after 1 time-unit settle.
